// File: rtl/wombat_stats_poller_if.sv
// AXI4-Lite read-channel bundle (AR/R only) between the stats poller and the
// register block slave port.
interface wombat_stats_poller_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic                  M_AXI_ARVALID;
    logic                  M_AXI_ARREADY;
    logic [DATA_WIDTH-1:0] M_AXI_RDATA;
    logic [1:0]            M_AXI_RRESP;
    logic                  M_AXI_RVALID;
    logic                  M_AXI_RREADY;

    modport master (
        output M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
        input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
    );

    modport slave (
        input  M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
        output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
    );
endinterface

// File: rtl/wombat_stats_poller.sv
// Periodically sweeps the three clear-on-read counters over AXI4-Lite and
// keeps lossless 64-bit running totals of them.
module wombat_stats_poller #(
    parameter logic [31:0] C_BASE_ADDRESS     = 32'h0000_0000,
    parameter int          C_S_AXI_ADDR_WIDTH = 32,
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter logic [31:0] C_OFF_PKTIN        = 32'h10,
    parameter logic [31:0] C_OFF_PKTOUT       = 32'h14,
    parameter logic [31:0] C_OFF_RESULT       = 32'h18,
    parameter int          C_POLL_PERIOD      = 1000,
    parameter int          C_TIMEOUT          = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        poll_now,
    input  logic        clear_totals,
    output logic [63:0] pktin_total,
    output logic [63:0] pktout_total,
    output logic [63:0] result_total,
    output logic [7:0]  err_count,
    output logic        stall,
    output logic        busy,
    output logic        sweep_done,
    wombat_stats_poller_if.master m_axi
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    localparam logic [31:0] PERIOD_RELOAD = 32'(C_POLL_PERIOD - 1);
    localparam logic [31:0] TIMEOUT_LAST  = 32'(C_TIMEOUT - 1);
    localparam logic [31:0] OFFSETS [3]   = '{C_OFF_PKTIN, C_OFF_PKTOUT, C_OFF_RESULT};

    state_t                        state_reg;
    logic [1:0]                    idx_reg;
    logic [31:0]                   timer_reg;
    logic [31:0]                   phase_reg;
    logic                          pending_reg;
    logic [63:0]                   total_reg [3];
    logic [7:0]                    err_reg;
    logic                          stall_reg;
    logic                          busy_reg;
    logic                          sweep_done_reg;
    logic [C_S_AXI_ADDR_WIDTH-1:0] araddr_reg;
    logic                          arvalid_reg;
    logic                          rready_reg;

    logic [C_S_AXI_ADDR_WIDTH-1:0] sweep_addr [3];
    logic [63:0]                   rdata_ext;
    logic                          start_idle;

    for (genvar gi = 0; gi < 3; gi++) begin : g_addr
        assign sweep_addr[gi] = C_S_AXI_ADDR_WIDTH'(C_BASE_ADDRESS | OFFSETS[gi]);
    end

    assign rdata_ext  = {{(64 - C_S_AXI_DATA_WIDTH){1'b0}}, m_axi.M_AXI_RDATA};
    assign start_idle = poll_now | pending_reg | (enable & (timer_reg == 32'd0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            idx_reg        <= 2'd0;
            timer_reg      <= PERIOD_RELOAD;
            phase_reg      <= 32'd0;
            pending_reg    <= 1'b0;
            for (int i = 0; i < 3; i++) total_reg[i] <= 64'd0;
            err_reg        <= 8'd0;
            stall_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            sweep_done_reg <= 1'b0;
            araddr_reg     <= '0;
            arvalid_reg    <= 1'b0;
            rready_reg     <= 1'b0;
        end else begin
            sweep_done_reg <= 1'b0;
            if (clear_totals) begin
                for (int i = 0; i < 3; i++) total_reg[i] <= 64'd0;
                err_reg   <= 8'd0;
                stall_reg <= 1'b0;
            end
            if (poll_now && state_reg != S_IDLE) pending_reg <= 1'b1;

            case (state_reg)
                S_IDLE: begin
                    if (start_idle) begin
                        state_reg   <= S_ADDR;
                        idx_reg     <= 2'd0;
                        araddr_reg  <= sweep_addr[0];
                        arvalid_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        phase_reg   <= 32'd0;
                        pending_reg <= 1'b0;
                    end else if (enable) begin
                        timer_reg <= timer_reg - 32'd1;
                    end
                end
                S_ADDR: begin
                    if (m_axi.M_AXI_ARREADY) begin
                        state_reg   <= S_DATA;
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        phase_reg   <= 32'd0;
                    end else if (phase_reg == TIMEOUT_LAST) begin
                        stall_reg <= 1'b1;
                    end else begin
                        phase_reg <= phase_reg + 32'd1;
                    end
                end
                S_DATA: begin
                    if (m_axi.M_AXI_RVALID) begin
                        rready_reg <= 1'b0;
                        phase_reg  <= 32'd0;
                        // Clear is folded in before the add so a clear-on-read value is never lost.
                        if (m_axi.M_AXI_RRESP == 2'b00)
                            total_reg[idx_reg] <= (clear_totals ? 64'd0 : total_reg[idx_reg]) + rdata_ext;
                        else if (clear_totals)
                            err_reg <= 8'd1;
                        else if (err_reg != 8'hFF)
                            err_reg <= err_reg + 8'd1;
                        if (idx_reg == 2'd2) begin
                            state_reg      <= S_DONE;
                            sweep_done_reg <= 1'b1;
                        end else begin
                            state_reg   <= S_ADDR;
                            idx_reg     <= idx_reg + 2'd1;
                            araddr_reg  <= sweep_addr[idx_reg + 2'd1];
                            arvalid_reg <= 1'b1;
                        end
                    end else if (phase_reg == TIMEOUT_LAST) begin
                        stall_reg <= 1'b1;
                    end else begin
                        phase_reg <= phase_reg + 32'd1;
                    end
                end
                S_DONE: begin
                    timer_reg <= PERIOD_RELOAD;
                    if (pending_reg || poll_now) begin
                        state_reg   <= S_ADDR;
                        idx_reg     <= 2'd0;
                        araddr_reg  <= sweep_addr[0];
                        arvalid_reg <= 1'b1;
                        phase_reg   <= 32'd0;
                        pending_reg <= 1'b0;
                    end else begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign pktin_total         = total_reg[0];
    assign pktout_total        = total_reg[1];
    assign result_total        = total_reg[2];
    assign err_count           = err_reg;
    assign stall               = stall_reg;
    assign busy                = busy_reg;
    assign sweep_done          = sweep_done_reg;
    assign m_axi.M_AXI_ARADDR  = araddr_reg;
    assign m_axi.M_AXI_ARVALID = arvalid_reg;
    assign m_axi.M_AXI_RREADY  = rready_reg;

endmodule

// File: doc/wombat_stats_poller.md
# wombat_stats_poller

AXI4-Lite read-only master that periodically sweeps the three clear-on-read counter registers of the wombat CPU register block (pktin, pktout, result). It accumulates each 32-bit read into a 64-bit running total, so software and local logic see lossless long-term statistics. The block sits beside the host AXI-Lite interconnect port on the register block's slave interface and drives only the AR/R channels.

## Interface

Parameters:

- C_BASE_ADDRESS, 32'h00000000: register block base; ARADDR = C_BASE_ADDRESS | offset.
- C_S_AXI_ADDR_WIDTH, 32: AXI address width.
- C_S_AXI_DATA_WIDTH, 32: AXI data width (only 32 supported).
- C_OFF_PKTIN, 32'h10: pktin register offset (sweep index 0).
- C_OFF_PKTOUT, 32'h14: pktout register offset (sweep index 1).
- C_OFF_RESULT, 32'h18: result register offset (sweep index 2).
- C_POLL_PERIOD, 1000: cycles between automatic sweep starts; must be ≥ 2.
- C_TIMEOUT, 64: wait cycles in one AXI phase before the stall flag sets.

Ports:

- clk  in  1  single clock for all logic, including the AXI side.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  allows periodic sweeps.
- poll_now  in  1  one-cycle request for an immediate sweep.
- clear_totals  in  1  one-cycle request to zero totals, err_count and stall.
- pktin_total  out  64  accumulated pktin.
- pktout_total  out  64  accumulated pktout.
- result_total  out  64  accumulated result.
- err_count  out  8  saturating count of reads returning RRESP != OKAY.
- stall  out  1  sticky; set when any phase exceeds C_TIMEOUT.
- busy  out  1  high whenever the FSM is not IDLE.
- sweep_done  out  1  one-cycle pulse at the end of each sweep.
- M_AXI_ARADDR  out  C_S_AXI_ADDR_WIDTH  read address.
- M_AXI_ARVALID  out  1  read address valid.
- M_AXI_ARREADY  in  1  read address ready.
- M_AXI_RDATA  in  32  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RVALID  in  1  read data valid.
- M_AXI_RREADY  out  1  read data ready.

## Operation

- All outputs are registered.
- Reset values: all outputs 0; idx = 0; period timer = C_POLL_PERIOD-1; pending = 0.
- FSM states:
  - IDLE → ADDR: on sweep start (timer expiry, poll_now, or pending). idx = 0.
  - ADDR: ARVALID=1 and ARADDR = base | offset[idx], both held stable until ARVALID&ARREADY. Then → DATA.
  - DATA: RREADY=1 until RVALID. On the RVALID&RREADY beat:
    - RRESP == 00: total[idx] += zero-extended RDATA.
    - RRESP != 00: err_count += 1, saturating at 255; total unchanged.
    - If idx < 2: idx++, → ADDR. If idx == 2: → DONE.
  - DONE: sweep_done=1 for one cycle; timer reloads to C_POLL_PERIOD-1; → IDLE.
- Period timer:
  - Decrements in IDLE only while enable=1, and holds while enable=0.
  - Expiry is the IDLE cycle with timer == 0 and enable=1; the sweep starts that cycle.
- poll_now:
  - In IDLE: starts a sweep immediately, regardless of enable.
  - Outside IDLE: sets pending. At DONE, pending makes the FSM go straight back to ADDR (a DONE pulse still occurs), and pending clears on that start.
- Totals wrap modulo 2^64.
- clear_totals:
  - Zeroes all totals, err_count and stall, in any state.
  - If it coincides with an accumulate beat, the affected total becomes RDATA: clear is applied first, then the add. This keeps clear-on-read data from being lost.
  - It does not abort an in-flight sweep.
- Timeout:
  - A phase counter counts cycles in ADDR or DATA and resets on each state change.
  - Reaching C_TIMEOUT sets stall.
  - The transaction is never abandoned: ARVALID is not withdrawn and RREADY stays high, per AXI rules.
- Reset asserted mid-transaction forces IDLE immediately and drops ARVALID/RREADY. Totals are lost.

## Timing

- Sweep start to ARVALID high: 1 cycle.
- ARREADY handshake cycle to RREADY high: next cycle.
- RVALID&RREADY beat to total update: next cycle. ARVALID for the next index rises in that same cycle.
- Minimum sweep with a zero-wait slave: 7 cycles (3 × 2 + DONE).
- busy falls the cycle after DONE unless pending.
- ARADDR is don't-care while ARVALID=0; RREADY is 0 outside DATA.

## Test plan

- Zero-wait slave returning 5, 7, 9; enable=1; C_POLL_PERIOD=20; run two sweeps → totals 10/14/18, two sweep_done pulses spaced 20+7 cycles apart, ARADDR sequence 0x10/0x14/0x18.
- RDATA=0xFFFFFFFF on pktin for 2^32+1 accumulations (force total to 0xFFFFFFFF_00000000 start) → carry into the upper word correct, then wrap to low value.
- Slave returns RRESP=2'b10 on index 1 → err_count=1, pktout_total unchanged, sweep completes. After 256 errors, err_count stays 255.
- ARREADY withheld 100 cycles with C_TIMEOUT=64 → stall=1 at cycle 64, ARVALID/ARADDR stable throughout, read completes normally when ARREADY is released.
- poll_now during ADDR of a sweep, plus clear_totals on the same cycle as the result beat with RDATA=3 → result_total=3, other totals 0, a second sweep starts directly after DONE.
- Assert reset while in DATA → ARVALID=0, RREADY=0, busy=0, all totals 0 asynchronously. After release, the first sweep occurs after C_POLL_PERIOD cycles.
